decoder_2x4_strobe: RTL and testbench
=====================================

Name: decoder_2x4_strobe

Overview:
- Inverse of the team's 4-to-2 priority encoder: accepts 2-bit codes over a valid/ready handshake, buffers them in a small FIFO and replays each one as a registered one-hot 4-bit strobe.
- Each strobe lasts a programmable number of cycles and is followed by a programmable idle gap.
- Sits downstream of encoder-generated indices and drives one-hot select/enable lines.

Parameters:
- PULSE_LEN, 2, cycles each one-hot strobe is held; legal range 1..15.
- GAP_LEN, 1, all-zero cycles inserted after each strobe; legal range 0..15.
- FIFO_DEPTH, 2, code buffer entries; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_code is valid this cycle.
- in_code  input  2  binary code to decode.
- in_ready  output  1  block can accept a code this cycle.
- out_onehot  output  4  registered one-hot strobe; 4'b0000 when not strobing.
- out_valid  output  1  high exactly while out_onehot is non-zero.
- fifo_level  output  $clog2(FIFO_DEPTH+1)  number of buffered codes.

Behaviour:
- Single clock domain, clk. Reset is asynchronous and active-high on rst.
- Reset values: out_onehot=0, out_valid=0, fifo_level=0, FSM=IDLE, counters=0.
- While rst is high, in_ready is forced to 0.
- Reset mid-operation:
  - Asynchronously clears outputs and flushes the FIFO.
  - No partial strobe or stale code reappears after rst is released.
- Accept rule:
  - A code is pushed on a rising edge where in_valid && in_ready.
  - in_ready = !rst && (fifo_level < FIFO_DEPTH), combinational from the registered level.
  - When the FIFO is full, in_ready is 0 even if a pop occurs on the same edge. There is no same-cycle full pass-through.
- No bypass: the FSM pops only when fifo_level > 0 before the edge.
  - Minimum latency: code pushed at edge E0 gives out_onehot valid from E1.
- Simultaneous push and pop on a non-full, non-empty FIFO: level is unchanged, and order is preserved (strict FIFO).
- FSM states:
  - IDLE: outputs 0. If level > 0: pop, load out_onehot = 1 << code, cnt = PULSE_LEN-1, go to PULSE.
  - PULSE: hold out_onehot.
    - If cnt > 0: decrement.
    - Else if GAP_LEN > 0: clear outputs, cnt = GAP_LEN-1, go to GAP.
    - Else, with GAP_LEN = 0: if level > 0, pop and reload (back-to-back strobes with no zero cycle); otherwise clear outputs and go to IDLE.
  - GAP: outputs 0.
    - If cnt > 0: decrement.
    - Else: if level > 0, pop and go to PULSE directly; otherwise go to IDLE.
- Throughput: one code per PULSE_LEN+GAP_LEN cycles.
- Widths:
  - cnt is $clog2(max(PULSE_LEN,GAP_LEN)+1) bits and never wraps.
  - FIFO pointers wrap modulo FIFO_DEPTH.
- out_onehot is always 0 or exactly one bit set; $onehot0 holds every cycle.

Decomposition:
- Shared package:
  - CODE_W=2 and ONEHOT_W=4 constants.
  - FSM state enum {IDLE, PULSE, GAP}.
  - A decode function code to one-hot.
- One sub-module, code_fifo: synchronous FIFO with parameters WIDTH and DEPTH, push/pop, level, full, empty, and asynchronous active-high reset.

Test Plan (PULSE_LEN=2, GAP_LEN=1, FIFO_DEPTH=2 unless stated):
- Reset: hold rst high 3 cycles -> out_onehot=0000, out_valid=0, in_ready=0, fifo_level=0; after release in_ready=1.
- Single code 2'b10 at E0 -> out_onehot=0100, out_valid=1 for E1..E2; 0000 at E3; FSM back to IDLE at E4.
- Codes 00, 01, 11 on consecutive cycles -> strobes 0001 ×2, 0000, 0010 ×2, 0000, 1000 ×2; order preserved; no code lost.
- Hold in_valid=1, code 01, for 12 cycles -> in_ready drops while level=2; strobes emitted equal handshakes accepted exactly, each 0010.
- GAP_LEN=0, push 00 then 11 -> out_onehot 0001, 0001, 1000, 1000 contiguous with out_valid never dropping.
- Assert rst on the second PULSE cycle with 1 code queued -> out_onehot=0 immediately; after release no strobe appears within 10 cycles.

Source files
------------

// File: rtl/decoder_2x4_strobe_pkg.sv
// Shared constants, FSM state type and the code-to-one-hot decode used by
// the 2-to-4 strobe decoder.
package decoder_2x4_strobe_pkg;

   localparam int CODE_W   = 2;
   localparam int ONEHOT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_e;

   function automatic logic [ONEHOT_W-1:0] decode_code(input logic [CODE_W-1:0] code);
      return ONEHOT_W'(1) << code;
   endfunction

endpackage

// File: rtl/decoder_2x4_strobe_if.sv
// Code-in / strobe-out bundle of the strobe decoder. The slave side is the
// decoder; the master side is whoever feeds codes and watches the strobes.
interface decoder_2x4_strobe_if
   import decoder_2x4_strobe_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) ();

   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

   logic                in_valid;
   logic [CODE_W-1:0]   in_code;
   logic                in_ready;
   logic [ONEHOT_W-1:0] out_onehot;
   logic                out_valid;
   logic [LVL_W-1:0]    fifo_level;

   modport master (
      output in_valid, in_code,
      input  in_ready, out_onehot, out_valid, fifo_level
   );

   modport slave (
      input  in_valid, in_code,
      output in_ready, out_onehot, out_valid, fifo_level
   );

endinterface

// File: rtl/decoder_2x4_strobe_code_fifo.sv
// Small synchronous FIFO holding pending codes. Pointers wrap modulo DEPTH,
// so DEPTH must be a power of two; push on full and pop on empty are ignored.
module code_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic [$clog2(DEPTH+1)-1:0] o_level,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_level == LVL_W'(DEPTH));
   assign o_empty = (r_level == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rd_ptr];
   assign o_level = r_level;

   // NOTE: storage has no reset; the level counter decides which entries are
   // live, so stale contents after a flush are never read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // NOTE: every sequential assignment is non-blocking so all registers
   // update from the same pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/decoder_2x4_strobe.sv
// Buffers 2-bit codes and replays each as a registered one-hot strobe lasting
// PULSE_LEN cycles, followed by GAP_LEN all-zero cycles.
module decoder_2x4_strobe
   import decoder_2x4_strobe_pkg::*;
#(
   parameter int PULSE_LEN  = 2,
   parameter int GAP_LEN    = 1,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   decoder_2x4_strobe_if.slave   bus
);

   localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
   localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] PULSE_RELOAD = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_RELOAD   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

   state_e              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [ONEHOT_W-1:0] r_onehot;

   state_e              w_state_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [ONEHOT_W-1:0] w_onehot_nxt;
   logic                w_pop;
   logic                w_push;
   logic [CODE_W-1:0]   w_head;
   logic [LVL_W-1:0]    w_level;
   logic                w_full;
   logic                w_empty;

   // Full blocks acceptance even when the FSM pops on the same edge.
   assign bus.in_ready   = !rst && !w_full;
   assign w_push         = bus.in_valid && bus.in_ready;
   assign bus.out_onehot = r_onehot;
   assign bus.out_valid  = |r_onehot;
   assign bus.fifo_level = w_level;

   code_fifo #(
      .WIDTH (CODE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (bus.in_code),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_level (w_level),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_onehot <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_onehot <= w_onehot_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_onehot_nxt = r_onehot;
      w_pop        = 1'b0;

      case (r_state)
         IDLE: begin
            w_onehot_nxt = '0;
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_onehot_nxt = decode_code(w_head);
               w_cnt_nxt    = PULSE_RELOAD;
               w_state_nxt  = PULSE;
            end
         end

         PULSE: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else if (GAP_LEN > 0) begin
               w_onehot_nxt = '0;
               w_cnt_nxt    = GAP_RELOAD;
               w_state_nxt  = GAP;
            end else if (!w_empty) begin
               // Zero-gap back-to-back reload keeps out_valid high throughout.
               w_pop        = 1'b1;
               w_onehot_nxt = decode_code(w_head);
               w_cnt_nxt    = PULSE_RELOAD;
            end else begin
               w_onehot_nxt = '0;
               w_state_nxt  = IDLE;
            end
         end

         GAP: begin
            w_onehot_nxt = '0;
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else if (!w_empty) begin
               w_pop        = 1'b1;
               w_onehot_nxt = decode_code(w_head);
               w_cnt_nxt    = PULSE_RELOAD;
               w_state_nxt  = PULSE;
            end else begin
               w_state_nxt = IDLE;
            end
         end

         default: begin
            w_onehot_nxt = '0;
            w_cnt_nxt    = '0;
            w_state_nxt  = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_decoder_2x4_strobe.sv
// Directed bench for decoder_2x4_strobe: a default instance (PULSE_LEN=2,
// GAP_LEN=1, FIFO_DEPTH=2) and a zero-gap instance share clock and reset.
module tb_decoder_2x4_strobe;
   import decoder_2x4_strobe_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   decoder_2x4_strobe_if #(.FIFO_DEPTH(2)) u_if  ();
   decoder_2x4_strobe_if #(.FIFO_DEPTH(2)) u_if0 ();

   decoder_2x4_strobe #(
      .PULSE_LEN  (2),
      .GAP_LEN    (1),
      .FIFO_DEPTH (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   decoder_2x4_strobe #(
      .PULSE_LEN  (2),
      .GAP_LEN    (0),
      .FIFO_DEPTH (2)
   ) dut_gap0 (
      .clk (clk),
      .rst (rst),
      .bus (u_if0.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance past the next rising edge; inputs are driven and outputs sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      u_if.in_valid  = 1'b0;
      u_if.in_code   = 2'b00;
      u_if0.in_valid = 1'b0;
      u_if0.in_code  = 2'b00;
      for (int i = 0; i < 3; i++) begin
         tick();
      end
      n_checks++;
      if (u_if.out_onehot !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_onehot: got %b expected 0000", u_if.out_onehot);
      end
      n_checks++;
      if (u_if.out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_valid: got %b expected 0", u_if.out_valid);
      end
      n_checks++;
      if (u_if.in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_ready: got %b expected 0", u_if.in_ready);
      end
      n_checks++;
      if (u_if.fifo_level !== 2'd0) begin
         n_errors++;
         $display("FAIL reset_level: got %0d expected 0", u_if.fifo_level);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (u_if.in_ready !== 1'b1 || u_if0.in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL release_ready: got %b/%b expected 1/1", u_if.in_ready, u_if0.in_ready);
      end
      tick();
   endtask

   task automatic test_single();
      logic [3:0] exp_oh [4];
      exp_oh = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
      u_if.in_valid = 1'b1;
      u_if.in_code  = 2'b10;
      tick();                                  // E0: push
      u_if.in_valid = 1'b0;
      n_checks++;
      if (u_if.fifo_level !== 2'd1 || u_if.out_onehot !== 4'b0000) begin
         n_errors++;
         $display("FAIL single_E0: level=%0d onehot=%b expected level=1 onehot=0000",
                  u_if.fifo_level, u_if.out_onehot);
      end
      for (int i = 0; i < 4; i++) begin
         tick();                               // E1..E4
         n_checks++;
         if (u_if.out_onehot !== exp_oh[i] || u_if.out_valid !== (exp_oh[i] != 4'b0000)) begin
            n_errors++;
            $display("FAIL single_E%0d: onehot=%b valid=%b expected onehot=%b",
                     i + 1, u_if.out_onehot, u_if.out_valid, exp_oh[i]);
         end
      end
      n_checks++;
      if (dut.r_state !== IDLE) begin
         n_errors++;
         $display("FAIL single_idle_E4: state=%0d expected IDLE", dut.r_state);
      end
   endtask

   task automatic test_sequence();
      logic [1:0] codes [3];
      logic [3:0] exp_oh [9];
      codes  = '{2'b00, 2'b01, 2'b11};
      exp_oh = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                 4'b1000, 4'b1000, 4'b0000};
      for (int i = 0; i < 3; i++) begin
         u_if.in_valid = 1'b1;
         u_if.in_code  = codes[i];
         n_checks++;
         if (u_if.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL seq_ready_%0d: got %b expected 1", i, u_if.in_ready);
         end
         tick();                               // E0..E2
         if (i >= 1) begin
            n_checks++;
            if (u_if.out_onehot !== exp_oh[i-1]) begin
               n_errors++;
               $display("FAIL seq_out_E%0d: got %b expected %b", i, u_if.out_onehot, exp_oh[i-1]);
            end
         end
      end
      u_if.in_valid = 1'b0;
      n_checks++;
      if (u_if.fifo_level !== 2'd2) begin
         n_errors++;
         $display("FAIL seq_level_E2: got %0d expected 2", u_if.fifo_level);
      end
      for (int i = 2; i < 9; i++) begin
         tick();                               // E3..E9
         n_checks++;
         if (u_if.out_onehot !== exp_oh[i]) begin
            n_errors++;
            $display("FAIL seq_out_E%0d: got %b expected %b", i + 1, u_if.out_onehot, exp_oh[i]);
         end
      end
      n_checks++;
      if (u_if.fifo_level !== 2'd0) begin
         n_errors++;
         $display("FAIL seq_drained: level=%0d expected 0", u_if.fifo_level);
      end
   endtask

   task automatic test_stream();
      int accepted   = 0;
      int strobe_cyc = 0;
      int bad_out    = 0;
      int bad_ready  = 0;
      u_if.in_code = 2'b01;
      for (int i = 0; i < 12; i++) begin
         u_if.in_valid = 1'b1;
         if (u_if.fifo_level == 2'd2 && u_if.in_ready !== 1'b0) bad_ready++;
         if (u_if.in_ready === 1'b1) accepted++;
         tick();
         if (u_if.out_onehot == 4'b0010) strobe_cyc++;
         else if (u_if.out_onehot != 4'b0000) bad_out++;
         if (u_if.out_valid !== (u_if.out_onehot != 4'b0000)) bad_out++;
      end
      u_if.in_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (u_if.out_onehot == 4'b0010) strobe_cyc++;
         else if (u_if.out_onehot != 4'b0000) bad_out++;
         if (u_if.out_valid !== (u_if.out_onehot != 4'b0000)) bad_out++;
      end
      n_checks++;
      if (accepted != 6) begin
         n_errors++;
         $display("FAIL stream_accepted: got %0d expected 6", accepted);
      end
      n_checks++;
      if (strobe_cyc != 12) begin
         n_errors++;
         $display("FAIL stream_strobe_cycles: got %0d expected 12", strobe_cyc);
      end
      n_checks++;
      if (bad_out != 0 || bad_ready != 0) begin
         n_errors++;
         $display("FAIL stream_shape: bad_out=%0d bad_ready=%0d expected 0/0", bad_out, bad_ready);
      end
   endtask

   task automatic test_gap0();
      logic [3:0] exp_oh [5];
      exp_oh = '{4'b0001, 4'b0001, 4'b1000, 4'b1000, 4'b0000};
      u_if0.in_valid = 1'b1;
      u_if0.in_code  = 2'b00;
      tick();                                  // E0
      u_if0.in_code  = 2'b11;
      tick();                                  // E1
      u_if0.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (u_if0.out_onehot !== exp_oh[i] || u_if0.out_valid !== (exp_oh[i] != 4'b0000)) begin
            n_errors++;
            $display("FAIL gap0_E%0d: onehot=%b valid=%b expected onehot=%b",
                     i + 1, u_if0.out_onehot, u_if0.out_valid, exp_oh[i]);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      int stray = 0;
      u_if.in_valid = 1'b1;
      u_if.in_code  = 2'b10;
      tick();                                  // E0: push 10
      u_if.in_code  = 2'b01;
      tick();                                  // E1: push 01, first PULSE cycle
      u_if.in_valid = 1'b0;
      tick();                                  // E2: second PULSE cycle
      n_checks++;
      if (u_if.out_onehot !== 4'b0100 || u_if.fifo_level !== 2'd1) begin
         n_errors++;
         $display("FAIL midrst_setup: onehot=%b level=%0d expected 0100/1",
                  u_if.out_onehot, u_if.fifo_level);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (u_if.out_onehot !== 4'b0000 || u_if.out_valid !== 1'b0 ||
          u_if.fifo_level !== 2'd0 || u_if.in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL midrst_async: onehot=%b valid=%b level=%0d ready=%b expected 0000/0/0/0",
                  u_if.out_onehot, u_if.out_valid, u_if.fifo_level, u_if.in_ready);
      end
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (u_if.out_onehot !== 4'b0000 || u_if.fifo_level !== 2'd0) stray++;
      end
      n_checks++;
      if (stray != 0) begin
         n_errors++;
         $display("FAIL midrst_after: %0d cycles with activity, expected 0", stray);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_single();
      test_sequence();
      test_stream();
      test_gap0();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
